// File: rtl/mean_stream_ctrl.sv
// Stream sequencer around the N-tap mean filter: credit-gated enables, partial-window
// suppression, zero-sample drain at block end and a filter reset between blocks.
module mean_stream_ctrl #(
   parameter int WIDTH = 25,
   parameter int N     = 32,
   parameter int LAT   = 38,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic             f_rst,
   output logic             f_en,
   output logic [WIDTH-1:0] f_data,
   input  logic [WIDTH-1:0] f_o_data,
   output logic             busy,
   output logic             short_blk
);
   // state | meaning
   // RUN   | forward accepted samples to the filter under credit
   // FLUSH | feed LAT zero samples to push the tail of the block out
   // CLEAR | one-cycle filter reset; last pending capture lands here
   typedef enum logic [1:0] {RUN, FLUSH, CLEAR} state_t;

   localparam int FL_W = $clog2(LAT + 1);
   localparam logic [CNT_W-1:0] K_FIRST = CNT_W'(N + LAT);
   localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LAT);
   localparam logic [CNT_W-1:0] N_C     = CNT_W'(N);
   localparam logic [CNT_W-1:0] MAX_BLK = {CNT_W{1'b1}} - LAT_C;
   localparam logic [FL_W-1:0]  FL_END  = FL_W'(LAT - 1);

   state_t           state;
   logic [CNT_W-1:0] k, nreal, k_next, nreal_eff;
   logic [FL_W-1:0]  flush_cnt;
   logic             pend_push, pend_last;
   logic [WIDTH-1:0] fifo_data [2];
   logic             fifo_last [2];
   logic             rd_ptr, wr_ptr;
   logic [1:0]       fifo_cnt;
   logic [2:0]       occ;
   logic             pop, credit_ok, accept;

   always_comb begin
      m_valid   = (fifo_cnt != 2'd0);
      m_data    = fifo_data[rd_ptr];
      m_last    = m_valid && fifo_last[rd_ptr];
      pop       = m_valid && m_ready;
      // a capture already in flight counts against the two FIFO slots
      occ       = {1'b0, fifo_cnt} + {2'b0, pend_push};
      credit_ok = occ < (3'd2 + {2'b0, pop});
      s_ready   = !rst && (state == RUN) && credit_ok;
      accept    = s_valid && s_ready;
      f_en      = (state == RUN) ? accept : (!rst && (state == FLUSH) && credit_ok);
      f_data    = (!rst && (state == RUN)) ? s_data : '0;
      f_rst     = rst || (state == CLEAR);
      busy      = !rst && (state != RUN);
      k_next    = k + CNT_W'(1);
      nreal_eff = nreal + CNT_W'(accept);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         k         <= '0;
         nreal     <= '0;
         flush_cnt <= '0;
         pend_push <= 1'b0;
         pend_last <= 1'b0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         fifo_cnt  <= 2'd0;
         short_blk <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         short_blk <= 1'b0;
         pend_push <= f_en && (k_next >= K_FIRST) && (k_next <= nreal_eff + LAT_C);
         pend_last <= f_en && (k_next == nreal_eff + LAT_C);
         if (f_en)
            k <= k_next;

         if (pend_push) begin
            fifo_data[wr_ptr] <= f_o_data;
            fifo_last[wr_ptr] <= pend_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + 2'(pend_push) - 2'(pop);

         case (state)
            RUN: begin
               if (accept) begin
                  nreal <= nreal_eff;
                  if (s_last || (nreal_eff == MAX_BLK)) begin
                     state     <= FLUSH;
                     flush_cnt <= '0;
                  end
               end
            end
            FLUSH: begin
               if (f_en) begin
                  flush_cnt <= flush_cnt + FL_W'(1);
                  if (flush_cnt == FL_END) begin
                     state     <= CLEAR;
                     short_blk <= (nreal < N_C);
                  end
               end
            end
            CLEAR: begin
               k     <= '0;
               nreal <= '0;
               state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: doc/mean_stream_ctrl.md
Name: mean_stream_ctrl

Overview:
- Sequencer that wraps the N-tap mean filter datapath and presents it as a framed valid/ready stream block.
- The filter only advances on its enable, so this block does four things:
  - issues filter enables under downstream credit;
  - suppresses partial-window outputs at block start;
  - injects zero samples at block end to drain the pipeline;
  - resets the filter between blocks.
- Sits between the sample source and any consumer of filtered data.

Parameters:
- WIDTH, 25, sample/result width (two's complement).
- N, 32, filter window length (power of two).
- LAT, 38, filter latency in enables: output captured after enable k averages samples k-LAT-N+1 .. k-LAT.
- CNT_W, 16, width of sample/enable counters; max block length 2^CNT_W-LAT-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when s_valid&&s_ready.
- s_data  in  WIDTH  input sample.
- s_last  in  1  marks final sample of a block.
- m_valid  out  1  output result valid.
- m_ready  in  1  consumer accepts when m_valid&&m_ready.
- m_data  out  WIDTH  filtered result.
- m_last  out  1  final result of a block.
- f_rst  out  1  filter synchronous reset.
- f_en  out  1  filter data_i_en.
- f_data  out  WIDTH  filter data_i.
- f_o_data  in  WIDTH  filter data_o.
- busy  out  1  high in FLUSH/CLEAR.
- short_blk  out  1  one-cycle pulse: block ended with fewer than N samples.

Behaviour:
- Reset: state=RUN, counters 0, FIFO empty. Outputs: m_valid=0, m_last=0, m_data=0, busy=0, short_blk=0, f_en=0, f_data=0. f_rst=1 while rst=1.
- Output buffer: 2-entry FIFO {data,last}.
  - Credit rule: an enable may issue only if occupancy + pending_capture - pop_this_cycle < 2. This sustains 1 result/cycle with m_ready held high.
  - m_valid = FIFO non-empty; head drives m_data/m_last.
- Capture: f_en is registered into pend. Enable index k (1-based, counted since the last filter reset) is tagged on issue.
  - The cycle after each enable, f_o_data is pushed iff N+LAT <= k <= nreal+LAT, where nreal = real samples in the block.
  - m_last is set on the push where k == nreal+LAT.
- RUN:
  - s_ready = credit_ok. f_en = s_valid&&s_ready. f_data = s_data. nreal increments per accept.
  - Accepted s_last, or nreal reaching the max block length, goes to FLUSH.
- FLUSH:
  - s_ready=0, busy=1.
  - f_en = credit_ok, f_data=0, for exactly LAT enables; then go to CLEAR.
  - If nreal<N: enables are still issued but nothing is pushed; short_blk pulses on CLEAR entry.
- CLEAR:
  - One cycle: f_rst=1, busy=1, s_ready=0, f_en=0.
  - The last pending capture still samples f_o_data at this edge, since the filter reset takes effect at the same edge.
  - Counters k and nreal are cleared; go to RUN.
- Ordering and stall rules:
  - FIFO contents survive CLEAR; results of consecutive blocks stay ordered.
  - A stalled m_ready only stalls f_en; samples are never dropped and the filter never advances without an enable.
- Mid-operation reset: rst in any state discards the FIFO, the pending capture and the counters. f_rst asserts. The next cycle is RUN with s_ready high (FIFO empty).
- s_last on a cycle where s_ready=0 has no effect until accepted.
- m_data is bit-exact f_o_data; the block does no arithmetic on data.

Test Plan:
- Bench setup: N=4, LAT=8, behavioural filter model with an 8-enable delay and arithmetic shift.
  1. Block 4,8,12,16,20,24 (last on 24), m_ready=1 → results 10, 14, 18; m_last only on 18. s_ready low for exactly 9 cycles (8 FLUSH + 1 CLEAR), with f_rst pulsing once.
  2. Same block with m_ready toggling 1/0 every cycle → identical result sequence. FIFO never exceeds 2. No f_en while credit exhausted.
  3. Block 7,7,7 (last on third) → no m_valid, short_blk single pulse. Next block 1,2,3,4 → result 2.5 truncated to 2, with m_last.
  4. Samples -4,-4,-4,-4,-8 (last) → results -4, -5. f_data is 0 during all 8 FLUSH enables.
  5. rst asserted during FLUSH with one result queued → m_valid=0 next cycle, f_rst=1. Fresh block 8,8,8,8 → single result 8 with m_last.
  6. Two back-to-back blocks (second presented immediately after CLEAR) → results of block 1 fully precede block 2's. Exactly one m_last per block.
